// File: rtl/ones_frame_acc_pkg.sv
// Shared definitions for the ones_frame_acc frame popcount accumulator:
// FSM states, result width, default frame-length width and a saturating adder.
package ones_frame_acc_pkg;

    localparam int unsigned CNT_W     = 32;
    localparam int unsigned DEF_LEN_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } state_t;

    // Clamps at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/get1num_add.sv
// Combinational count of set bits in one input word, zero-extended to the
// accumulator width.
module get1num_add
    import ones_frame_acc_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_data,
    output logic [CNT_W-1:0]  ret
);

    always_comb begin
        ret = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            ret = ret + CNT_W'(i_data[i]);
        end
    end

endmodule

// File: rtl/ones_frame_acc.sv
// Accumulates the number of 1 bits and the word count over a frame of input
// words, then presents the result until the downstream side takes it.
module ones_frame_acc
    import ones_frame_acc_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    input  logic              i_last,
    output logic              o_ready,
    output logic [CNT_W-1:0]  o_cnt,
    output logic [LEN_W-1:0]  o_len,
    output logic              o_ovf,
    output logic              o_valid,
    input  logic              i_ready
);

    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] word_ones;
    logic [CNT_W-1:0] sum;
    logic [CNT_W-1:0] sum_nxt;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] len_nxt;
    logic             ovf;
    logic             ovf_nxt;
    logic             accept;
    logic             res_take;

    get1num_add #(
        .DATA_W (DATA_W)
    ) u_get1num_add (
        .i_data (i_data),
        .ret    (word_ones)
    );

    // Ready is gated by reset so nothing is offered while the block is held in reset.
    assign o_ready  = rst_n && (state != HOLD);
    assign accept   = i_valid && o_ready;
    assign res_take = (state == HOLD) && o_valid && i_ready;

    assign sum_nxt = sat_add(sum, word_ones);
    assign len_nxt = (len == LEN_MAX) ? len : len + LEN_W'(1);
    assign ovf_nxt = ovf || (len == LEN_MAX);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = i_last ? HOLD : ACC;
            ACC:  if (accept && i_last) state_nxt = HOLD;
            HOLD: if (res_take) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum     <= '0;
            len     <= '0;
            ovf     <= 1'b0;
            o_cnt   <= '0;
            o_len   <= '0;
            o_ovf   <= 1'b0;
            o_valid <= 1'b0;
        end else if (accept) begin
            if (i_last) begin
                o_cnt   <= sum_nxt;
                o_len   <= len_nxt;
                o_ovf   <= ovf_nxt;
                o_valid <= 1'b1;
            end else begin
                sum <= sum_nxt;
                len <= len_nxt;
                ovf <= ovf_nxt;
            end
        end else if (res_take) begin
            o_valid <= 1'b0;
            sum     <= '0;
            len     <= '0;
            ovf     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ones_frame_acc.sv
// Self-checking bench for ones_frame_acc: directed frames plus randomized
// frames checked against a per-frame arithmetic reference model.
module tb_ones_frame_acc;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned LEN_MAX = (1 << LEN_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] i_data = '0;
    logic              i_valid = 1'b0;
    logic              i_last = 1'b0;
    logic              o_ready;
    logic [31:0]       o_cnt;
    logic [LEN_W-1:0]  o_len;
    logic              o_ovf;
    logic              o_valid;
    logic              i_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    ones_frame_acc #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_last  (i_last),
        .o_ready (o_ready),
        .o_cnt   (o_cnt),
        .o_len   (o_len),
        .o_ovf   (o_ovf),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: total ones over the frame, length clamped at the counter max.
    function automatic void model(input logic [7:0] w[$], output int unsigned cnt,
                                  output int unsigned len, output bit ovf);
        longint unsigned s = 0;
        foreach (w[k]) s += $countones(w[k]);
        cnt = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
        len = (w.size() > LEN_MAX) ? LEN_MAX : w.size();
        ovf = (w.size() > LEN_MAX);
    endfunction

    task automatic expect_result(input string tag, input int unsigned cnt,
                                 input int unsigned len, input bit ovf);
        chk({tag, ".valid"}, 32'(o_valid), 32'd1);
        chk({tag, ".cnt"},   o_cnt,        cnt);
        chk({tag, ".len"},   32'(o_len),   len);
        chk({tag, ".ovf"},   32'(o_ovf),   32'(ovf));
        chk({tag, ".ready"}, 32'(o_ready), 32'd0);
    endtask

    task automatic send_frame(input string tag, input logic [7:0] w[$],
                              input int unsigned gap_max, input int unsigned bp,
                              input bit keep_valid, input logic [7:0] next_w);
        int unsigned ecnt;
        int unsigned elen;
        bit          eovf;
        int unsigned n;
        model(w, ecnt, elen, eovf);
        i_ready = (bp == 0);
        foreach (w[k]) begin
            i_valid = 1'b1;
            i_data  = w[k];
            i_last  = (k == w.size() - 1);
            n = 0;
            while (!o_ready && n < 64) begin
                step();
                n++;
            end
            if (k == 0) chk({tag, ".accept_ready"}, 32'(o_ready), 32'd1);
            step();
            if (k == w.size() - 1) begin
                if (keep_valid) begin
                    i_data = next_w;
                    i_last = 1'b1;
                end else begin
                    i_valid = 1'b0;
                    i_data  = 8'($urandom);
                    i_last  = 1'($urandom);
                end
            end else begin
                i_valid = 1'b0;
                i_data  = 8'($urandom);
                i_last  = 1'($urandom);
                repeat ($urandom_range(gap_max, 0)) step();
            end
        end
        expect_result(tag, ecnt, elen, eovf);
        repeat (bp) begin
            step();
            expect_result({tag, ".bp"}, ecnt, elen, eovf);
        end
        i_ready = 1'b1;
        step();
        chk({tag, ".done_valid"}, 32'(o_valid), 32'd0);
        chk({tag, ".done_ready"}, 32'(o_ready), 32'd1);
        if (!keep_valid) i_ready = 1'($urandom);
    endtask

    initial begin
        logic [7:0] q[$];

        // Reset state
        i_valid = 1'b1;
        i_data  = 8'hFF;
        i_last  = 1'b1;
        step();
        step();
        chk("rst.ready", 32'(o_ready), 32'd0);
        chk("rst.valid", 32'(o_valid), 32'd0);
        chk("rst.cnt",   o_cnt,        32'd0);
        chk("rst.len",   32'(o_len),   32'd0);
        chk("rst.ovf",   32'(o_ovf),   32'd0);
        i_valid = 1'b0;
        rst_n   = 1'b1;
        #1;
        chk("rel.ready", 32'(o_ready), 32'd1);
        step();
        chk("rel.ready2", 32'(o_ready), 32'd1);

        q = {8'h71};
        send_frame("single", q, 0, 0, 1'b0, 8'h00);

        q = {8'hFF, 8'h00, 8'h0F};
        send_frame("gaps", q, 3, 0, 1'b0, 8'h00);

        q = {8'h03};
        send_frame("backpressure", q, 0, 5, 1'b0, 8'h00);

        q = {8'h01};
        send_frame("b2b_first", q, 0, 0, 1'b1, 8'hF0);
        q = {8'hF0};
        send_frame("b2b_second", q, 0, 0, 1'b0, 8'h00);

        // Reset mid-frame
        i_valid = 1'b1;
        i_data  = 8'hFF;
        i_last  = 1'b0;
        step();
        step();
        i_valid = 1'b0;
        rst_n   = 1'b0;
        step();
        chk("midrst.ready", 32'(o_ready), 32'd0);
        chk("midrst.valid", 32'(o_valid), 32'd0);
        rst_n = 1'b1;
        q = {8'h80};
        send_frame("after_midrst", q, 0, 0, 1'b0, 8'h00);

        // Reset while a result is pending
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'h0F;
        i_last  = 1'b1;
        step();
        i_valid = 1'b0;
        chk("holdrst.pending", 32'(o_valid), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("holdrst.valid", 32'(o_valid), 32'd0);
        chk("holdrst.ready", 32'(o_ready), 32'd1);
        q = {8'h0C, 8'h01};
        send_frame("after_holdrst", q, 1, 0, 1'b0, 8'h00);

        // Length boundary: exactly max, one past, well past
        q = {};
        repeat (LEN_MAX) q.push_back(8'hFF);
        send_frame("len_max", q, 0, 0, 1'b0, 8'h00);
        q.push_back(8'hFF);
        send_frame("len_max_p1", q, 0, 0, 1'b0, 8'h00);
        q.push_back(8'hFF);
        send_frame("len_sat17", q, 0, 1, 1'b0, 8'h00);

        for (int f = 0; f < 25; f++) begin
            q = {};
            repeat ($urandom_range(20, 1)) q.push_back(8'($urandom));
            send_frame($sformatf("rand%0d", f), q, 2, $urandom_range(3, 0), 1'b0, 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
